// File: rtl/out_port_receiver.sv
// Output-port receive stage: filters the switched word stream by destination, buffers
// accepted packets store-and-forward, and replays them over a sop/eop/vld/ready handshake.
`timescale 1ns/1ps
module out_port_receiver #(
   parameter int DATA_WIDTH      = 32,
   parameter int PORT_NUB_TOTAL  = 16,
   parameter int DATA_LENGTH_MAX = 512,
   parameter int PRIORITY        = 8,
   parameter int PORT_ID         = 0,
   parameter int BUF_DEPTH       = 1024,
   parameter int DESC_DEPTH      = 16,
   localparam int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL),
   localparam int WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX),
   localparam int WIDTH_PRIORITY = $clog2(PRIORITY)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH_SEL-1:0]      rx,
   input  logic [WIDTH_SEL-1:0]      tx,
   input  logic                      vld,
   input  logic [DATA_WIDTH-1:0]     data,
   input  logic                      rd_ready,
   output logic                      rd_vld,
   output logic                      rd_sop,
   output logic                      rd_eop,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic [WIDTH_SEL-1:0]      rd_src,
   output logic [WIDTH_PRIORITY-1:0] rd_priority,
   output logic [WIDTH_LENGTH-1:0]   rd_length,
   output logic [15:0]               pkt_cnt,
   output logic [15:0]               drop_cnt
);
   localparam int WS = WIDTH_SEL;
   localparam int WL = WIDTH_LENGTH;
   localparam int WP = WIDTH_PRIORITY;
   localparam int AW = $clog2(BUF_DEPTH);
   localparam int DW = $clog2(DESC_DEPTH);
   localparam int CW = (AW + 2 > WL + 1) ? AW + 2 : WL + 1;

   typedef enum logic [1:0] {IDLE, ACCEPT, DISCARD} state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t              state_q;
   logic [WL-1:0]       len_q, cnt_q;
   logic [WS-1:0]       src_q;
   logic [WP-1:0]       pri_q;
   logic [AW:0]         wr_ptr_q, rd_ptr_q;
   logic [DW:0]         dwr_q, drd_q;
   logic [15:0]         pkt_cnt_q, drop_cnt_q;

   logic [DATA_WIDTH-1:0] mem   [BUF_DEPTH];
   logic [WS-1:0]         d_src [DESC_DEPTH];
   logic [WP-1:0]         d_pri [DESC_DEPTH];
   logic [WL-1:0]         d_len [DESC_DEPTH];

   logic                  rd_vld_q, rd_sop_q, rd_eop_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [WS-1:0]         rd_src_q;
   logic [WP-1:0]         rd_pri_q;
   logic [WL-1:0]         rd_len_q, rd_idx_q;

   logic [WL-1:0] hdr_len;
   logic [WP-1:0] hdr_pri;
   logic [AW:0]   used_w;
   logic [DW:0]   desc_cnt;
   logic [CW-1:0] free_w;
   logic          desc_full, space_ok, last_beat, wr_en, push;
   logic          xfer, pop, start, cont, rd_fetch;
   logic [DW-1:0] head;

   assign hdr_len   = data[WL-1:0];
   assign hdr_pri   = data[WL+WP-1:WL];
   assign used_w    = wr_ptr_q - rd_ptr_q;
   assign desc_cnt  = dwr_q - drd_q;
   assign desc_full = (desc_cnt == (DW+1)'(DESC_DEPTH));
   // A word fetched into the output register this cycle already counts as free space.
   assign free_w    = CW'(BUF_DEPTH) - CW'(used_w) + CW'(rd_fetch);
   assign space_ok  = !desc_full && (free_w >= CW'(hdr_len));
   assign last_beat = vld && (cnt_q == len_q - 1'b1);
   assign wr_en     = (state_q == ACCEPT) && vld;
   assign push      = wr_en && last_beat;

   assign xfer     = rd_vld_q && rd_ready;
   assign pop      = xfer && rd_eop_q;
   assign start    = (!rd_vld_q && (desc_cnt != '0)) || (pop && (desc_cnt > (DW+1)'(1)));
   assign cont     = xfer && !rd_eop_q;
   assign rd_fetch = start || cont;
   assign head     = pop ? drd_q[DW-1:0] + 1'b1 : drd_q[DW-1:0];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q[AW-1:0]] <= data;
      if (push) begin
         d_src[dwr_q[DW-1:0]] <= src_q;
         d_pri[dwr_q[DW-1:0]] <= pri_q;
         d_len[dwr_q[DW-1:0]] <= len_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         cnt_q      <= '0;
         src_q      <= '0;
         pri_q      <= '0;
         wr_ptr_q   <= '0;
         dwr_q      <= '0;
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (vld) begin
               cnt_q <= '0;
               len_q <= hdr_len;
               if (tx != WS'(PORT_ID)) begin
                  if (hdr_len != '0) state_q <= DISCARD;
               end else if (hdr_len == '0) begin
                  drop_cnt_q <= sat_inc(drop_cnt_q);
               end else if (!space_ok) begin
                  drop_cnt_q <= sat_inc(drop_cnt_q);
                  state_q    <= DISCARD;
               end else begin
                  src_q   <= rx;
                  pri_q   <= hdr_pri;
                  state_q <= ACCEPT;
               end
            end
            ACCEPT: if (vld) begin
               wr_ptr_q <= wr_ptr_q + 1'b1;
               cnt_q    <= cnt_q + 1'b1;
               if (last_beat) begin
                  dwr_q     <= dwr_q + 1'b1;
                  pkt_cnt_q <= sat_inc(pkt_cnt_q);
                  state_q   <= IDLE;
               end
            end
            DISCARD: if (vld) begin
               cnt_q <= cnt_q + 1'b1;
               if (last_beat) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Read side: the output register is loaded on packet start or on every accepted non-last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_q  <= 1'b0;
         rd_sop_q  <= 1'b0;
         rd_eop_q  <= 1'b0;
         rd_data_q <= '0;
         rd_src_q  <= '0;
         rd_pri_q  <= '0;
         rd_len_q  <= '0;
         rd_idx_q  <= '0;
         rd_ptr_q  <= '0;
         drd_q     <= '0;
      end else begin
         if (pop) drd_q <= drd_q + 1'b1;
         if (start) begin
            rd_vld_q  <= 1'b1;
            rd_sop_q  <= 1'b1;
            rd_eop_q  <= (d_len[head] == WL'(1));
            rd_data_q <= mem[rd_ptr_q[AW-1:0]];
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            rd_idx_q  <= WL'(1);
            rd_src_q  <= d_src[head];
            rd_pri_q  <= d_pri[head];
            rd_len_q  <= d_len[head];
         end else if (cont) begin
            rd_sop_q  <= 1'b0;
            rd_eop_q  <= (rd_idx_q + 1'b1 == rd_len_q);
            rd_data_q <= mem[rd_ptr_q[AW-1:0]];
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            rd_idx_q  <= rd_idx_q + 1'b1;
         end else if (pop) begin
            rd_vld_q <= 1'b0;
            rd_sop_q <= 1'b0;
            rd_eop_q <= 1'b0;
         end
      end
   end

   assign rd_vld      = rd_vld_q;
   assign rd_sop      = rd_sop_q;
   assign rd_eop      = rd_eop_q;
   assign rd_data     = rd_data_q;
   assign rd_src      = rd_src_q;
   assign rd_priority = rd_pri_q;
   assign rd_length   = rd_len_q;
   assign pkt_cnt     = pkt_cnt_q;
   assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_out_port_receiver.sv
// Directed bench for out_port_receiver (PORT_ID=2, 16-word buffer, 4-entry descriptor FIFO).
`timescale 1ns/1ps
module tb_out_port_receiver;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  rx = '0, tx = '0;
   logic        vld = 1'b0;
   logic [31:0] data = '0;
   logic        rd_ready;
   logic        rd_vld, rd_sop, rd_eop;
   logic [31:0] rd_data;
   logic [3:0]  rd_src;
   logic [2:0]  rd_priority;
   logic [8:0]  rd_length;
   logic [15:0] pkt_cnt, drop_cnt;

   logic rdy_man = 1'b0, tog_en = 1'b0, tog = 1'b0;
   assign rd_ready = tog_en ? tog : rdy_man;

   out_port_receiver #(.PORT_ID(2), .BUF_DEPTH(16), .DESC_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .vld(vld), .data(data),
      .rd_ready(rd_ready), .rd_vld(rd_vld), .rd_sop(rd_sop), .rd_eop(rd_eop),
      .rd_data(rd_data), .rd_src(rd_src), .rd_priority(rd_priority),
      .rd_length(rd_length), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt));

   always #5 clk = ~clk;
   always @(posedge clk) begin
      #1 tog = ~tog;
   end

   int n_pass = 0, n_chk = 0;
   logic [31:0] q_data[$];
   logic        q_sop[$], q_eop[$];
   logic [31:0] exp_q[$];
   logic [3:0]  cap_src;
   logic [2:0]  cap_pri;
   logic [8:0]  cap_len;
   int          stall_seen = 0, stall_err = 0;
   logic        p_vld = 0, p_rdy = 0, p_sop = 0, p_eop = 0;
   logic [31:0] p_data = '0;

   always @(negedge clk) begin
      if (rd_vld && rd_ready) begin
         q_data.push_back(rd_data);
         q_sop.push_back(rd_sop);
         q_eop.push_back(rd_eop);
         if (rd_sop) begin
            cap_src = rd_src; cap_pri = rd_priority; cap_len = rd_length;
         end
      end
      if (p_vld && !p_rdy) begin
         stall_seen++;
         if (!rd_vld || rd_data !== p_data || rd_sop !== p_sop || rd_eop !== p_eop) stall_err++;
      end
      p_vld = rd_vld; p_rdy = rd_ready; p_data = rd_data; p_sop = rd_sop; p_eop = rd_eop;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_stream(input string tag);
      int bad = 0;
      chk({tag, " beats"}, q_data.size(), exp_q.size());
      for (int i = 0; i < q_data.size() && i < exp_q.size(); i++)
         if (q_data[i] !== exp_q[i]) bad++;
      chk({tag, " data"}, bad, 0);
   endtask

   function automatic int count1(input logic q[$]);
      int n = 0;
      foreach (q[i]) if (q[i]) n++;
      return n;
   endfunction

   task automatic clear_q();
      q_data.delete(); q_sop.delete(); q_eop.delete(); exp_q.delete();
   endtask

   task automatic beat(input logic [3:0] t, input logic [3:0] r, input logic [31:0] d);
      @(posedge clk); #1;
      vld = 1'b1; tx = t; rx = r; data = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         vld = 1'b0;
      end
   endtask

   task automatic send(input logic [3:0] t, input logic [3:0] r, input int pri,
                       input int len, input int base, input bit gaps);
      beat(t, r, (pri << 9) | len);
      for (int i = 0; i < len; i++) begin
         if (gaps) idle((i % 3) + 1);
         beat(t, r, base + i);
      end
      idle(1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; vld = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      clear_q();
   endtask

   int lat;

   initial begin
      // Reset state
      idle(2);
      chk("reset rd_vld", rd_vld, 0);
      chk("reset rd_data", rd_data, 0);
      chk("reset pkt_cnt", pkt_cnt, 0);
      chk("reset drop_cnt", drop_cnt, 0);
      rst_n = 1'b1;
      idle(1);

      // Basic accepted packet
      rdy_man = 1'b1;
      send(4'd2, 4'd5, 3, 10, 1, 1'b0);
      idle(15);
      for (int i = 1; i <= 10; i++) exp_q.push_back(i);
      chk_stream("basic");
      chk("basic first sop", q_sop.size() > 0 ? q_sop[0] : 1'b0, 1);
      chk("basic last eop", q_eop.size() == 10 ? q_eop[9] : 1'b0, 1);
      chk("basic sop count", count1(q_sop), 1);
      chk("basic rd_src", cap_src, 5);
      chk("basic rd_priority", cap_pri, 3);
      chk("basic rd_length", cap_len, 10);
      chk("basic pkt_cnt", pkt_cnt, 1);

      // Foreign destination ignored, then own packet
      do_reset();
      send(4'd7, 4'd1, 1, 10, 50, 1'b0);
      idle(10);
      chk("foreign beats", q_data.size(), 0);
      chk("foreign pkt_cnt", pkt_cnt, 0);
      chk("foreign drop_cnt", drop_cnt, 0);
      send(4'd2, 4'd1, 0, 4, 101, 1'b0);
      idle(10);
      for (int i = 101; i <= 104; i++) exp_q.push_back(i);
      chk_stream("after foreign");
      chk("after foreign eop count", count1(q_eop), 1);

      // Buffer space exhaustion with egress stalled
      do_reset();
      rdy_man = 1'b0;
      send(4'd2, 4'd3, 1, 10, 1, 1'b0);
      send(4'd2, 4'd3, 1, 8, 21, 1'b0);
      send(4'd2, 4'd4, 2, 6, 31, 1'b0);
      idle(5);
      chk("space drop_cnt", drop_cnt, 1);
      chk("space pkt_cnt", pkt_cnt, 2);
      chk("space held rd_vld", rd_vld, 1);
      chk("space held rd_data", rd_data, 1);
      chk("space held rd_sop", rd_sop, 1);
      rdy_man = 1'b1;
      idle(25);
      for (int i = 1; i <= 10; i++) exp_q.push_back(i);
      for (int i = 31; i <= 36; i++) exp_q.push_back(i);
      chk_stream("space");
      chk("space sop count", count1(q_sop), 2);
      chk("space eop count", count1(q_eop), 2);
      chk("space second rd_src", cap_src, 4);
      chk("space second rd_length", cap_len, 6);

      // Input gaps and toggling egress ready
      do_reset();
      stall_seen = 0; stall_err = 0;
      tog_en = 1'b1;
      send(4'd2, 4'd5, 3, 10, 1, 1'b1);
      idle(40);
      tog_en = 1'b0;
      for (int i = 1; i <= 10; i++) exp_q.push_back(i);
      chk_stream("gaps");
      chk("gaps stalls observed", stall_seen > 0, 1);
      chk("gaps stall stability", stall_err, 0);
      chk("gaps rd_src", cap_src, 5);
      chk("gaps pkt_cnt", pkt_cnt, 1);

      // Zero-length and single-beat packets
      do_reset();
      rdy_man = 1'b1;
      beat(4'd2, 4'd6, 0);
      idle(5);
      chk("len0 drop_cnt", drop_cnt, 1);
      chk("len0 beats", q_data.size(), 0);
      beat(4'd2, 4'd6, (4 << 9) | 1);
      beat(4'd2, 4'd6, 77);
      lat = 0;
      while (!rd_vld && lat < 10) begin
         @(posedge clk); #1;
         vld = 1'b0;
         lat++;
      end
      chk("len1 latency within 3", lat <= 3, 1);
      idle(5);
      exp_q.push_back(77);
      chk_stream("len1");
      chk("len1 sop", q_sop.size() == 1 ? q_sop[0] : 1'b0, 1);
      chk("len1 eop", q_eop.size() == 1 ? q_eop[0] : 1'b0, 1);
      chk("len1 rd_priority", cap_pri, 4);
      chk("len1 pkt_cnt", pkt_cnt, 1);

      // Reset in the middle of a packet
      do_reset();
      beat(4'd2, 4'd9, (1 << 9) | 10);
      for (int i = 0; i < 4; i++) beat(4'd2, 4'd9, 200 + i);
      beat(4'd2, 4'd9, 204);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(10);
      chk("midreset beats", q_data.size(), 0);
      chk("midreset pkt_cnt", pkt_cnt, 0);
      chk("midreset drop_cnt", drop_cnt, 0);
      chk("midreset rd_vld", rd_vld, 0);
      send(4'd2, 4'd8, 2, 3, 51, 1'b0);
      idle(10);
      for (int i = 51; i <= 53; i++) exp_q.push_back(i);
      chk_stream("post reset");
      chk("post reset rd_src", cap_src, 8);
      chk("post reset pkt_cnt", pkt_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, required finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/out_port_receiver.md
Name: out_port_receiver

Overview:
Output-side receive stage, directly downstream of in_module, on the out_clk domain. It consumes the switched word stream (rx, tx, vld, data), keeps only packets whose destination tx equals this port's PORT_ID, and stores them store-and-forward in a local payload buffer. It then presents each stored packet with a sop/eop/vld/ready handshake to the port's egress logic. Packets are dropped and counted when buffer space is insufficient, because the input stream has no backpressure.

Parameters:
DATA_WIDTH, `DATA_WIDTH (32), payload word width
PORT_NUB_TOTAL, `PORT_NUB_TOTAL (16), number of switch ports; WIDTH_SEL = $clog2(PORT_NUB_TOTAL)
DATA_LENGTH_MAX, `DATA_LENGTH_MAX (512), max payload words per packet; WIDTH_LENGTH = $clog2(DATA_LENGTH_MAX)
PRIORITY, `PRIORITY (8), number of priority levels; WIDTH_PRIORITY = $clog2(PRIORITY)
PORT_ID, 0, this port's index; compared against tx
BUF_DEPTH, 1024, payload buffer depth in words (power of 2, >= DATA_LENGTH_MAX)
DESC_DEPTH, 16, descriptor FIFO depth in packets (power of 2)

Ports:
clk  in  1  out_clk domain clock
rst_n  in  1  asynchronous active-low reset
rx  in  WIDTH_SEL  source port of current beat
tx  in  WIDTH_SEL  destination port of current beat
vld  in  1  beat valid; no backpressure
data  in  DATA_WIDTH  header or payload word
rd_ready  in  1  egress accepts current output beat
rd_vld  out  1  output beat valid
rd_sop  out  1  first payload beat of packet
rd_eop  out  1  last payload beat of packet
rd_data  out  DATA_WIDTH  payload word
rd_src  out  WIDTH_SEL  source port of packet; stable while rd_vld
rd_priority  out  WIDTH_PRIORITY  packet priority; stable while rd_vld
rd_length  out  WIDTH_LENGTH  payload length; stable while rd_vld
pkt_cnt  out  16  accepted packets, saturating
drop_cnt  out  16  dropped packets (no space or length 0), saturating

Behaviour:
- Reset (async, rst_n=0): all outputs 0; both FIFOs empty; input FSM goes to IDLE; counters cleared. A partially received packet is discarded and is not counted.
- Packet format: first vld beat is the header. data[WIDTH_LENGTH-1:0] is the payload length L. data[WIDTH_LENGTH+WIDTH_PRIORITY-1:WIDTH_LENGTH] is the priority. rx and tx are sampled on the header beat.
- The next L vld beats are payload. Cycles with vld=0 between beats are gaps: they are ignored and never terminate a packet.
- Input FSM states: IDLE, ACCEPT, DISCARD.
- IDLE on a header beat:
  - tx != PORT_ID -> DISCARD; no counter change.
  - tx == PORT_ID and L == 0 -> stay IDLE; drop_cnt+1.
  - tx == PORT_ID and (buffer free < L or descriptor FIFO full) -> DISCARD; drop_cnt+1.
  - Otherwise -> ACCEPT; latch rx, priority and L.
- Space check: "free" is evaluated in the header cycle and includes a read completing in that same cycle.
- ACCEPT: each payload beat is written to the buffer in the cycle it arrives.
  - On the L-th beat, push descriptor {src, priority, L} and increment pkt_cnt; the descriptor is visible to the read side on the next cycle.
  - Then -> IDLE.
- DISCARD: counts L payload beats without writing, then -> IDLE.
- A header may arrive in the cycle immediately after a packet's last beat; it is handled normally from IDLE.
- Read side: when the descriptor FIFO is non-empty and no packet is in progress, assert rd_vld with rd_sop=1 and the first word. This occurs no earlier than 1 cycle after the descriptor push.
- Handshake:
  - A beat transfers when rd_vld && rd_ready.
  - rd_data and rd_sop/rd_eop stay stable while rd_vld && !rd_ready.
  - rd_eop=1 on beat L; for L=1, rd_sop and rd_eop are both 1.
  - After eop transfers, pop the descriptor. A following stored packet may start in the next cycle, so back-to-back is allowed.
- Total latency, last input beat to first rd_vld: at most 3 cycles when the FIFO is empty.
- Pointers: buffer and descriptor pointers wrap modulo depth with one extra bit for full/empty. The buffer fill exactly to BUF_DEPTH is legal.
- Counters saturate at 16'hFFFF.
- Simultaneous buffer write and read in one cycle must be supported with no data loss.

Test Plan:
- PORT_ID=2; header tx=2, rx=5, priority=3, L=10, payload 1..10; rd_ready=1 -> rd_sop with data 1, 10 beats, rd_eop with data 10; rd_src=5, rd_priority=3, rd_length=10; pkt_cnt=1.
- Header tx=7, L=10 -> no rd_vld; pkt_cnt=0, drop_cnt=0. A following tx=2, L=4 packet is output correctly.
- BUF_DEPTH=16, rd_ready=0: send L=10, then L=8 -> first packet is accepted and the second is dropped (drop_cnt=1). Then send L=6 -> accepted, buffer exactly full. Raise rd_ready -> 10 beats then 6 beats, in order.
- Payload with vld gaps of 1-3 cycles and rd_ready toggling every cycle -> output identical to the gap-free case; rd_data is held stable while stalled.
- Header L=0 -> drop_cnt=1, no output. Header L=1 -> a single beat with rd_sop=rd_eop=1.
- rst_n asserted at the 5th payload beat of an L=10 packet, then released -> no output, counters 0. Next L=3 packet is received correctly.
